// File: rtl/lua_pkg.sv
// Shared Lua core definitions: sequencer state encoding and opcode constants
// used by both the sequencer and the decode stage.
package lua_pkg;

    localparam int unsigned OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_MOVE   = 6'd0;
    localparam logic [OPC_W-1:0] OP_LOADK  = 6'd1;
    localparam logic [OPC_W-1:0] OP_JMP    = 6'd22;
    localparam logic [OPC_W-1:0] OP_RETURN = 6'd30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/lua_core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the Lua core.
// Optional fetch watchdog enabled by defining LUA_SEQ_FETCH_TIMEOUT_EN.
module lua_core_sequencer
    import lua_pkg::*;
#(
    parameter int unsigned      PC_W    = 16,
    parameter logic [OPC_W-1:0] HALT_OP = OP_RETURN,
    parameter int unsigned      TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            en_id,
    output logic            en_ex,
    output logic            en_wb,
    input  logic            ex_busy,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            running,
    output logic            halted,
    output logic            fetch_err
);

    seq_state_t      state;
    logic            br_taken_q;
    logic [PC_W-1:0] br_target_q;

    assign imem_addr = pc;

`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
    logic [7:0] wd_cnt;
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
`else
    // Watchdog limit is meaningless without the counter.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
    assign fetch_err      = 1'b0;
`endif

    // Enables and status are registered alongside the state transition so they
    // track the state register exactly (Moore) without a decode stage.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            inst        <= '0;
            retired     <= '0;
            en_id       <= 1'b0;
            en_ex       <= 1'b0;
            en_wb       <= 1'b0;
            imem_req    <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
            wd_cnt      <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= '0;
                        imem_req <= 1'b1;
                        running  <= 1'b1;
`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        inst     <= imem_rdata;
                        state    <= S_DECODE;
                        imem_req <= 1'b0;
                        en_id    <= 1'b1;
                    end
`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= S_HALT;
                        imem_req  <= 1'b0;
                        running   <= 1'b0;
                        halted    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                S_DECODE: begin
                    state <= S_EXEC;
                    en_id <= 1'b0;
                    en_ex <= 1'b1;
                end
                S_EXEC: begin
                    if (!ex_busy) begin
                        state       <= S_WB;
                        en_ex       <= 1'b0;
                        en_wb       <= 1'b1;
                        br_taken_q  <= br_taken;
                        br_target_q <= br_target;
                    end
                end
                S_WB: begin
                    en_wb <= 1'b0;
                    pc    <= br_taken_q ? br_target_q : pc + 1'b1;
                    if (retired != 16'hFFFF) begin
                        retired <= retired + 16'd1;
                    end
                    if (inst[OPC_W-1:0] == HALT_OP) begin
                        state   <= S_HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lua_core_sequencer.sv
// Self-checking bench for lua_core_sequencer: directed vector table, corner
// sequences (halt, reset mid-EXEC, watchdog) and a randomized instruction stream.
module tb_lua_core_sequencer;

    localparam int unsigned PC_W = 16;

    logic            clk = 1'b0;
    logic            n_reset;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     inst;
    logic            en_id;
    logic            en_ex;
    logic            en_wb;
    logic            ex_busy;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic [15:0]     retired;
    logic            running;
    logic            halted;
    logic            fetch_err;

    always #5 clk = ~clk;

    lua_core_sequencer #(.PC_W(PC_W), .HALT_OP(6'd30), .TIMEOUT(4)) dut (
        .clk(clk), .n_reset(n_reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst),
        .en_id(en_id), .en_ex(en_ex), .en_wb(en_wb),
        .ex_busy(ex_busy), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .retired(retired), .running(running), .halted(halted),
        .fetch_err(fetch_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Per-instruction measurements filled by run_instr
    int          m_cycles, m_fetch, m_id, m_ex, m_wb, m_onehot_bad, m_addr_bad;
    logic [31:0] m_inst_id, m_inst_wb;
    logic        m_done;

    task automatic do_reset();
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_req"}, imem_req, 1'b1);
        chk({tag, "_start_addr"}, imem_addr, 0);
    endtask

    // Runs one instruction starting at the negedge of its first FETCH cycle;
    // returns at the negedge after its WB cycle. Idle inputs get random junk.
    task automatic run_instr(input int wt, input int bz, input logic tk,
                             input logic [15:0] tgt, input logic [31:0] data,
                             input logic [15:0] exp_addr);
        m_cycles = 0; m_fetch = 0; m_id = 0; m_ex = 0; m_wb = 0;
        m_onehot_bad = 0; m_addr_bad = 0; m_done = 1'b0;
        m_inst_id = '0; m_inst_wb = '0;
        for (int t = 0; t < 100 && !m_done; t++) begin
            if (int'(en_id) + int'(en_ex) + int'(en_wb) > 1) m_onehot_bad++;
            if (imem_req) begin
                m_fetch++;
                if (imem_addr !== exp_addr) m_addr_bad++;
            end
            if (en_id) begin m_id++; m_inst_id = inst; end
            if (en_ex) m_ex++;
            if (en_wb) begin m_wb++; m_inst_wb = inst; m_done = 1'b1; end
            if (imem_req || en_id || en_ex || en_wb) m_cycles++;
            imem_ack   = imem_req ? (m_fetch == wt + 1) : 1'($urandom_range(0, 1));
            imem_rdata = (imem_req && imem_ack) ? data : $urandom;
            ex_busy    = en_ex ? (m_ex <= bz) : 1'($urandom_range(0, 1));
            if (en_ex && !ex_busy) begin
                br_taken  = tk;
                br_target = tgt;
            end else begin
                br_taken  = 1'($urandom_range(0, 1));
                br_target = 16'($urandom);
            end
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start    = 1'b0;
        imem_ack = 1'b0;
        ex_busy  = 1'b0;
        if (!m_done) chk("instr_complete", 0, 1);
    endtask

    task automatic instr_checks(input string tag, input int wt, input int bz,
                                input logic [31:0] data);
        chk({tag, "_cycles"}, m_cycles, 4 + wt + bz);
        chk({tag, "_fetch_cycles"}, m_fetch, wt + 1);
        chk({tag, "_id_cycles"}, m_id, 1);
        chk({tag, "_ex_cycles"}, m_ex, bz + 1);
        chk({tag, "_wb_cycles"}, m_wb, 1);
        chk({tag, "_onehot_bad"}, m_onehot_bad, 0);
        chk({tag, "_addr_bad"}, m_addr_bad, 0);
        chk({tag, "_inst_id"}, m_inst_id, data);
        chk({tag, "_inst_wb"}, m_inst_wb, data);
    endtask

    task automatic post_checks(input string tag, input logic [15:0] exp_pc,
                               input logic [15:0] exp_ret, input logic exp_halt);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_retired"}, retired, exp_ret);
        chk({tag, "_halted"}, halted, exp_halt);
        chk({tag, "_running"}, running, !exp_halt);
        chk({tag, "_req"}, imem_req, !exp_halt);
        chk({tag, "_fetch_err"}, fetch_err, 0);
    endtask

    typedef struct {
        int          wt;
        int          bz;
        logic        tk;
        logic [15:0] tgt;
        logic [31:0] data;
        int          exp_cyc;
        logic [15:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          bad;
        int          cnt;
        logic [15:0] pc_m, ret_m, prev_pc;
        int          wt, bz;
        logic        tk, hlt;
        logic [15:0] tgt;
        logic [31:0] data;

        vecs[0] = '{0, 0, 1'b0, 16'h0000, 32'h0000_0041, 4, 16'h0001, 1'b0};
        vecs[1] = '{3, 2, 1'b0, 16'h1234, 32'h0000_1C82, 9, 16'h0002, 1'b0};
        vecs[2] = '{0, 0, 1'b1, 16'h0040, 32'h0000_0005, 4, 16'h0040, 1'b0};
        vecs[3] = '{1, 1, 1'b1, 16'hFFFF, 32'hABCD_0007, 6, 16'hFFFF, 1'b0};
        vecs[4] = '{0, 1, 1'b0, 16'h0001, 32'h0000_0008, 5, 16'h0000, 1'b0};
        vecs[5] = '{2, 0, 1'b1, 16'h1234, 32'h0000_005E, 6, 16'h1234, 1'b1};

        n_reset = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        ex_busy = 1'b0; br_taken = 1'b0; br_target = '0;
        @(negedge clk);
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_inst", inst, 0);
        chk("rst_retired", retired, 0);
        chk("rst_enables", {en_id, en_ex, en_wb, imem_req}, 0);
        chk("rst_status", {running, halted, fetch_err}, 0);

        do_start("tbl");
        prev_pc = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i].wt, vecs[i].bz, vecs[i].tk, vecs[i].tgt, vecs[i].data, prev_pc);
            chk($sformatf("v%0d_cycles", i), m_cycles, vecs[i].exp_cyc);
            chk($sformatf("v%0d_onehot", i), m_onehot_bad, 0);
            chk($sformatf("v%0d_addr", i), m_addr_bad, 0);
            chk($sformatf("v%0d_ex_cycles", i), m_ex, vecs[i].bz + 1);
            chk($sformatf("v%0d_inst", i), m_inst_wb, vecs[i].data);
            post_checks($sformatf("v%0d", i), vecs[i].exp_pc, 16'(i + 1), vecs[i].exp_halt);
            prev_pc = vecs[i].exp_pc;
        end

        // HALT is sticky: start and ack pulses do nothing
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom;
            @(negedge clk);
            if (imem_req || !halted || running || en_id) bad++;
        end
        start = 1'b0; imem_ack = 1'b0;
        chk("halt_sticky_bad", bad, 0);
        chk("halt_pc_hold", pc, 16'h1234);
        do_reset();
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_pc", pc, 0);

        // Reset asserted while in EXEC aborts at the next edge
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0041;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("rexec_in_exec", en_ex, 1);
        ex_busy = 1'b1; n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1; ex_busy = 1'b0;
        chk("rexec_enables", {en_id, en_ex, en_wb, imem_req}, 0);
        chk("rexec_running", running, 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req || en_id || en_ex || running || inst != 0) bad++;
        end
        imem_ack = 1'b0;
        chk("rexec_stray_ack_bad", bad, 0);

        // Randomized stream against the instruction-level model
        do_start("rnd");
        pc_m = 16'h0000; ret_m = 16'h0000;
        for (int n = 0; n < 40; n++) begin
            wt   = $urandom_range(0, 3);
            bz   = $urandom_range(0, 3);
            tk   = 1'($urandom_range(0, 1));
            tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            data = $urandom;
            if (n % 13 == 12) data[5:0] = 6'd30;
            else if (data[5:0] == 6'd30) data[5:0] = 6'd31;
            hlt = (data[5:0] == 6'd30);
            run_instr(wt, bz, tk, tgt, data, pc_m);
            instr_checks($sformatf("r%0d", n), wt, bz, data);
            pc_m  = tk ? tgt : pc_m + 16'd1;
            ret_m = (ret_m == 16'hFFFF) ? ret_m : ret_m + 16'd1;
            post_checks($sformatf("r%0d", n), pc_m, ret_m, hlt);
            if (hlt) begin
                do_reset();
                do_start($sformatf("r%0d_restart", n));
                pc_m = 16'h0000; ret_m = 16'h0000;
            end
        end

        do_reset();
`ifdef LUA_SEQ_FETCH_TIMEOUT_EN
        do_start("wd");
        cnt = 0;
        for (int t = 0; t < 20 && imem_req; t++) begin
            cnt++;
            @(negedge clk);
        end
        chk("wd_req_cycles", cnt, 4);
        chk("wd_fetch_err", fetch_err, 1);
        chk("wd_halted", halted, 1);
        chk("wd_req_drop", imem_req, 0);
        do_reset();
        chk("wd_rst_err", fetch_err, 0);
        do_start("wd2");
        for (int t = 0; t < 3; t++) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0041;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("wd_late_ack_id", en_id, 1);
        chk("wd_late_ack_inst", inst, 32'h0000_0041);
        chk("wd_late_ack_err", fetch_err, 0);
`else
        do_start("nowd");
        for (int t = 0; t < 10; t++) @(negedge clk);
        chk("nowd_req_held", imem_req, 1);
        chk("nowd_fetch_err", fetch_err, 0);
        chk("nowd_halted", halted, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
